ahb_apb_bridge_param: RTL and testbench

AHB_APB_BRIDGE_PARAM -- requirements
Module: ahb_apb_bridge_param

---
 rtl/ahb_apb_bridge_param_if.sv | 38 +++
 rtl/ahb_apb_bridge_param.sv | 158 +++++++++++++++
 tb/tb_ahb_apb_bridge_param.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_bridge_param_if.sv
// AHB-side and APB-side signal bundle for the AHB to APB bridge.
// The bridge takes the slave view; the surrounding fabric takes the master view.
interface ahb_apb_bridge_param_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                Hwrite;
    logic                Hreadyin;
    logic [1:0]          Htrans;
    logic [ADDR_W-1:0]   Haddr;
    logic [DATA_W-1:0]   Hwdata;
    logic                Hreadyout;
    logic [1:0]          Hresp;
    logic [DATA_W-1:0]   Hrdata;
    logic [NUM_SLV-1:0]  Pselx;
    logic                Penable;
    logic                Pwrite;
    logic [ADDR_W-1:0]   Paddr;
    logic [DATA_W-1:0]   Pwdata;
    logic [DATA_W-1:0]   Prdata;
    logic                Pready;
    logic                Pslverr;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata,
        input  Prdata, Pready, Pslverr,
        output Hreadyout, Hresp, Hrdata,
        output Pselx, Penable, Pwrite, Paddr, Pwdata
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata,
        output Prdata, Pready, Pslverr,
        input  Hreadyout, Hresp, Hrdata,
        input  Pselx, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/ahb_apb_bridge_param.sv
// AHB-lite to APB bridge: address decode into NUM_SLV windows,
// registered APB outputs, slave-error and timeout mapped to AHB ERROR.
module ahb_apb_bridge_param #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                NUM_SLV   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter logic [ADDR_W-1:0] SLV_SIZE  = 'h0400_0000,
    parameter int                TIMEOUT   = 16
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    ahb_apb_bridge_param_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2
    } state_t;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] ERR  = 2'b01;

    // Decode math is done wider than the bus so the window end cannot wrap
    localparam int EW = ADDR_W + 4;
    localparam logic [EW-1:0] LO = EW'(BASE_ADDR);
    localparam logic [EW-1:0] SZ = EW'(SLV_SIZE);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic                hready_q;
    logic [1:0]          hresp_q;
    logic [DATA_W-1:0]   hrdata_q;
    logic [NUM_SLV-1:0]  sel_q;
    logic [NUM_SLV-1:0]  psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;

    logic [NUM_SLV-1:0]  dec_sel;
    logic                in_rng;
    logic                htrans_ok;
    logic                accept;
    logic [EW-1:0]       haddr_w;

    assign haddr_w = EW'(bus.Haddr);

    always_comb begin
        dec_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            dec_sel[i] = (haddr_w >= LO + EW'(i) * SZ) &&
                         (haddr_w <  LO + EW'(i + 1) * SZ);
        end
    end

    assign in_rng    = |dec_sel;
    assign htrans_ok = (bus.Htrans == 2'b10) || (bus.Htrans == 2'b11);
    assign accept    = bus.Hreadyin && hready_q && htrans_ok;

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= OKAY;
            hrdata_q  <= '0;
            sel_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_q   <= IDLE;
                    hready_q  <= 1'b1;
                    hresp_q   <= OKAY;
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    if (accept) begin
                        paddr_q  <= bus.Haddr;
                        pwrite_q <= bus.Hwrite;
                        hready_q <= 1'b0;
                        if (!in_rng) begin
                            state_q <= ERR1;
                            hresp_q <= ERR;
                        end else begin
                            sel_q <= dec_sel;
                            cnt_q <= '0;
                            if (bus.Hwrite) begin
                                state_q <= WDATA;
                            end else begin
                                state_q <= SETUP;
                                psel_q  <= dec_sel;
                            end
                        end
                    end
                end
                WDATA: begin
                    pwdata_q <= bus.Hwdata;
                    psel_q   <= sel_q;
                    cnt_q    <= '0;
                    state_q  <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.Pready) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (bus.Pslverr) begin
                            state_q <= ERR1;
                            hresp_q <= ERR;
                        end else begin
                            state_q  <= DONE;
                            hready_q <= 1'b1;
                            if (!pwrite_q) hrdata_q <= bus.Prdata;
                        end
                    end else if (TIMEOUT > 0 &&
                                 cnt_q == CW'(TIMEOUT - 1)) begin
                        // Slave never answered: abandon and report ERROR
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        state_q   <= ERR1;
                        hresp_q   <= ERR;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ERR1: begin
                    hready_q <= 1'b1;
                    state_q  <= ERR2;
                end
                ERR2: begin
                    hresp_q <= OKAY;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Hreadyout = hready_q;
    assign bus.Hresp     = hresp_q;
    assign bus.Hrdata    = hrdata_q;
    assign bus.Pselx     = psel_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Directed table-driven bench for the AHB to APB bridge,
// plus hand sequences for timeout and mid-access reset.
module tb_ahb_apb_bridge_param;

    logic clk;
    logic rst;

    ahb_apb_bridge_param_if #(
        .DATA_W(32), .ADDR_W(32), .NUM_SLV(4)
    ) bus ();

    ahb_apb_bridge_param #(
        .DATA_W(32), .ADDR_W(32), .NUM_SLV(4),
        .BASE_ADDR(32'h8000_0000), .SLV_SIZE(32'h0400_0000),
        .TIMEOUT(16)
    ) dut (
        .Hclk(clk),
        .Hreset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [1:0]  tr;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] prd;
        logic        prdy;
        logic        perr;
        logic        hin;
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [3:0]  e_sel;
        logic        e_en;
        logic        e_wr;
        logic [31:0] e_a;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tab[$];
    vec_t post[$];
    int checks = 0;
    int failures = 0;

    task automatic add(
        input bit p, input string nm,
        input logic [1:0] tr, input logic wr,
        input logic [31:0] a, input logic [31:0] wd,
        input logic [31:0] prd, input logic prdy,
        input logic perr, input logic hin,
        input logic e_rdy, input logic [1:0] e_resp,
        input logic [3:0] e_sel, input logic e_en,
        input logic e_wr, input logic [31:0] e_a,
        input logic [31:0] e_wd, input logic [31:0] e_rd
    );
        vec_t v;
        v.nm = nm; v.tr = tr; v.wr = wr; v.a = a;
        v.wd = wd; v.prd = prd; v.prdy = prdy;
        v.perr = perr; v.hin = hin;
        v.e_rdy = e_rdy; v.e_resp = e_resp;
        v.e_sel = e_sel; v.e_en = e_en; v.e_wr = e_wr;
        v.e_a = e_a; v.e_wd = e_wd; v.e_rd = e_rd;
        if (p) post.push_back(v);
        else tab.push_back(v);
    endtask

    task automatic check(
        input string nm,
        input logic [127:0] act,
        input logic [127:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] snap();
        return {23'd0, bus.Hreadyout, bus.Hresp,
                bus.Pselx, bus.Penable, bus.Pwrite,
                bus.Paddr, bus.Pwdata, bus.Hrdata};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input vec_t v);
        logic [127:0] exp;
        bus.Htrans   = v.tr;
        bus.Hwrite   = v.wr;
        bus.Haddr    = v.a;
        bus.Hwdata   = v.wd;
        bus.Prdata   = v.prd;
        bus.Pready   = v.prdy;
        bus.Pslverr  = v.perr;
        bus.Hreadyin = v.hin;
        step();
        exp = {23'd0, v.e_rdy, v.e_resp, v.e_sel,
               v.e_en, v.e_wr, v.e_a, v.e_wd, v.e_rd};
        check(v.nm, snap(), exp);
    endtask

    task automatic idle_in();
        bus.Htrans   = 2'b00;
        bus.Hwrite   = 1'b0;
        bus.Haddr    = '0;
        bus.Hwdata   = '0;
        bus.Prdata   = '0;
        bus.Pready   = 1'b1;
        bus.Pslverr  = 1'b0;
        bus.Hreadyin = 1'b1;
    endtask

    initial begin
        int n;
        // single write to slave 0, zero wait
        add(0, "w1_acc", 2, 1, 32'h8000_0004, 0, 0, 1, 0, 1,
            0, 0, 4'h0, 0, 1, 32'h8000_0004, 0, 0);
        add(0, "w1_wdat", 0, 0, 0, 32'hA3, 0, 1, 0, 1,
            0, 0, 4'h1, 0, 1, 32'h8000_0004, 32'hA3, 0);
        add(0, "w1_setup", 0, 0, 0, 0, 0, 1, 0, 1,
            0, 0, 4'h1, 1, 1, 32'h8000_0004, 32'hA3, 0);
        add(0, "w1_done", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 1, 32'h8000_0004, 32'hA3, 0);
        add(0, "w1_idle", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 1, 32'h8000_0004, 32'hA3, 0);
        // read slave 1 with two wait states; slverr while not ready
        add(0, "r2_acc", 2, 0, 32'h8400_0010, 0, 0, 1, 0, 1,
            0, 0, 4'h2, 0, 0, 32'h8400_0010, 32'hA3, 0);
        add(0, "r2_setup", 0, 0, 0, 0, 0, 0, 0, 1,
            0, 0, 4'h2, 1, 0, 32'h8400_0010, 32'hA3, 0);
        add(0, "r2_wait1", 0, 0, 0, 0, 0, 0, 0, 1,
            0, 0, 4'h2, 1, 0, 32'h8400_0010, 32'hA3, 0);
        add(0, "r2_wait2", 0, 0, 0, 0, 0, 0, 1, 1,
            0, 0, 4'h2, 1, 0, 32'h8400_0010, 32'hA3, 0);
        add(0, "r2_done", 0, 0, 0, 0, 32'h5A, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 32'h8400_0010, 32'hA3, 32'h5A);
        add(0, "r2_idle", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 32'h8400_0010, 32'hA3, 32'h5A);
        // out-of-range read; no accept in ERR1/ERR2
        add(0, "e3_acc", 3, 0, 32'h9000_0000, 0, 0, 1, 0, 1,
            0, 1, 4'h0, 0, 0, 32'h9000_0000, 32'hA3, 32'h5A);
        add(0, "e3_err1", 2, 0, 32'h8000_0000, 0, 0, 1, 0, 1,
            1, 1, 4'h0, 0, 0, 32'h9000_0000, 32'hA3, 32'h5A);
        add(0, "e3_err2", 2, 1, 32'h8000_0000, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 32'h9000_0000, 32'hA3, 32'h5A);
        add(0, "busy_ign", 1, 1, 32'h8000_0000, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 32'h9000_0000, 32'hA3, 32'h5A);
        add(0, "hrdyin_ign", 2, 1, 32'h8000_0000, 0, 0, 1, 0, 0,
            1, 0, 4'h0, 0, 0, 32'h9000_0000, 32'hA3, 32'h5A);
        // write to slave 3 answered with slverr
        add(0, "w4_acc", 2, 1, 32'h8C00_0000, 0, 0, 1, 0, 1,
            0, 0, 4'h0, 0, 1, 32'h8C00_0000, 32'hA3, 32'h5A);
        add(0, "w4_wdat", 0, 0, 0, 32'h11, 0, 1, 0, 1,
            0, 0, 4'h8, 0, 1, 32'h8C00_0000, 32'h11, 32'h5A);
        add(0, "w4_setup", 0, 0, 0, 0, 0, 1, 0, 1,
            0, 0, 4'h8, 1, 1, 32'h8C00_0000, 32'h11, 32'h5A);
        add(0, "w4_slverr", 0, 0, 0, 0, 0, 1, 1, 1,
            0, 1, 4'h0, 0, 1, 32'h8C00_0000, 32'h11, 32'h5A);
        add(0, "w4_err1", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 1, 4'h0, 0, 1, 32'h8C00_0000, 32'h11, 32'h5A);
        add(0, "w4_err2", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 1, 32'h8C00_0000, 32'h11, 32'h5A);
        // read then write accepted in DONE
        add(0, "b5_racc", 2, 0, 32'h8000_0000, 0, 0, 1, 0, 1,
            0, 0, 4'h1, 0, 0, 32'h8000_0000, 32'h11, 32'h5A);
        add(0, "b5_rset", 0, 0, 0, 0, 0, 1, 0, 1,
            0, 0, 4'h1, 1, 0, 32'h8000_0000, 32'h11, 32'h5A);
        add(0, "b5_rdone", 0, 0, 0, 0, 32'h77, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 32'h8000_0000, 32'h11, 32'h77);
        add(0, "b5_wacc", 2, 1, 32'h8800_0000, 0, 0, 1, 0, 1,
            0, 0, 4'h0, 0, 1, 32'h8800_0000, 32'h11, 32'h77);
        add(0, "b5_wdat", 0, 0, 0, 32'hCAFE, 0, 1, 0, 1,
            0, 0, 4'h4, 0, 1, 32'h8800_0000, 32'hCAFE, 32'h77);
        add(0, "b5_wset", 0, 0, 0, 0, 0, 1, 0, 1,
            0, 0, 4'h4, 1, 1, 32'h8800_0000, 32'hCAFE, 32'h77);
        add(0, "b5_wdone", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 1, 32'h8800_0000, 32'hCAFE, 32'h77);
        add(0, "b5_idle", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 1, 32'h8800_0000, 32'hCAFE, 32'h77);
        // errored read must not update Hrdata
        add(0, "e6_acc", 2, 0, 32'h8000_0000, 0, 0, 1, 0, 1,
            0, 0, 4'h1, 0, 0, 32'h8000_0000, 32'hCAFE, 32'h77);
        add(0, "e6_set", 0, 0, 0, 0, 0, 1, 0, 1,
            0, 0, 4'h1, 1, 0, 32'h8000_0000, 32'hCAFE, 32'h77);
        add(0, "e6_slverr", 0, 0, 0, 0, 32'hEE, 1, 1, 1,
            0, 1, 4'h0, 0, 0, 32'h8000_0000, 32'hCAFE, 32'h77);
        add(0, "e6_err1", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 1, 4'h0, 0, 0, 32'h8000_0000, 32'hCAFE, 32'h77);
        add(0, "e6_err2", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 32'h8000_0000, 32'hCAFE, 32'h77);
        // decode boundaries: just below base, last word of slave 3
        add(0, "lo_acc", 2, 0, 32'h7FFF_FFFC, 0, 0, 1, 0, 1,
            0, 1, 4'h0, 0, 0, 32'h7FFF_FFFC, 32'hCAFE, 32'h77);
        add(0, "lo_err1", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 1, 4'h0, 0, 0, 32'h7FFF_FFFC, 32'hCAFE, 32'h77);
        add(0, "lo_err2", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 32'h7FFF_FFFC, 32'hCAFE, 32'h77);
        add(0, "hi_acc", 2, 0, 32'h8FFF_FFFC, 0, 0, 1, 0, 1,
            0, 0, 4'h8, 0, 0, 32'h8FFF_FFFC, 32'hCAFE, 32'h77);
        add(0, "hi_set", 0, 0, 0, 0, 0, 1, 0, 1,
            0, 0, 4'h8, 1, 0, 32'h8FFF_FFFC, 32'hCAFE, 32'h77);
        add(0, "hi_done", 0, 0, 0, 0, 32'h31, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 32'h8FFF_FFFC, 32'hCAFE, 32'h31);
        add(0, "hi_idle", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 32'h8FFF_FFFC, 32'hCAFE, 32'h31);
        // after mid-access reset: clean state, then a normal write
        add(1, "x_idle", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 0, 0, 0, 0);
        add(1, "x_acc", 2, 1, 32'h8000_000C, 0, 0, 1, 0, 1,
            0, 0, 4'h0, 0, 1, 32'h8000_000C, 0, 0);
        add(1, "x_wdat", 0, 0, 0, 32'h42, 0, 1, 0, 1,
            0, 0, 4'h1, 0, 1, 32'h8000_000C, 32'h42, 0);
        add(1, "x_set", 0, 0, 0, 0, 0, 1, 0, 1,
            0, 0, 4'h1, 1, 1, 32'h8000_000C, 32'h42, 0);
        add(1, "x_done", 0, 0, 0, 0, 0, 1, 0, 1,
            1, 0, 4'h0, 0, 1, 32'h8000_000C, 32'h42, 0);

        idle_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", snap(), {23'd0, 1'b1, 104'd0});
        rst = 1'b0;

        foreach (tab[i]) run(tab[i]);

        // timeout: read with Pready held low
        idle_in();
        bus.Htrans = 2'b10;
        bus.Haddr  = 32'h8000_0008;
        step();
        check("to_setup", {124'd0, bus.Pselx}, 128'h1);
        idle_in();
        bus.Pready = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.Penable) n++;
            else break;
        end
        check("to_cycles", 128'(n), 128'd16);
        check("to_err1",
              {121'd0, bus.Hreadyout, bus.Hresp, bus.Pselx},
              {121'd0, 1'b0, 2'b01, 4'h0});
        step();
        check("to_err2", {125'd0, bus.Hreadyout, bus.Hresp},
              {125'd0, 1'b1, 2'b01});
        bus.Pready = 1'b1;
        step();
        check("to_idle",
              {93'd0, bus.Hreadyout, bus.Hresp, bus.Hrdata},
              {93'd0, 1'b1, 2'b00, 32'h31});

        // reset pulse in the middle of an ACCESS phase
        bus.Htrans = 2'b10;
        bus.Haddr  = 32'h8000_0004;
        step();
        idle_in();
        bus.Pready = 1'b0;
        step();
        check("rs_access", {123'd0, bus.Pselx, bus.Penable},
              {123'd0, 4'h1, 1'b1});
        rst = 1'b1;
        #1;
        check("rs_async", snap(), {23'd0, 1'b1, 104'd0});
        @(negedge clk);
        rst = 1'b0;
        bus.Pready = 1'b1;

        foreach (post[i]) run(post[i]);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
